// File: rtl/risc16_imem_responder.sv
// RiSC-16 instruction-memory responder.
// Fetch requests read the instruction store in the cycle they are accepted and
// land in a 2-entry in-order response queue. Requests for addresses beyond the
// implemented store produce a zero word flagged with rsp_err. A separate load
// port fills the store, and flush empties the queue on a PC redirect.
module risc16_imem_responder #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_err,
  input  logic              flush,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [15:0]       fetch_cnt
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] q_data [2];
  logic [ADDR_W-1:0] q_addr [2];
  logic [1:0]        q_err;
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count;

  logic              req_in_range;
  logic              ld_in_range;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] fetch_word;

  // Address range checks for the fetch and load ports.
  always_comb begin
    req_in_range = {1'b0, req_addr} < DEPTH_X;
    ld_in_range  = {1'b0, ld_addr} < DEPTH_X;
  end

  // Handshakes: a full queue can still accept when the head leaves on the same
  // edge; a flush blocks new requests and swallows any response handshake.
  always_comb begin
    rsp_valid = (count != 2'd0);
    req_ready = !flush && ((count != 2'd2) || (rsp_valid && rsp_ready));
    push      = req_valid && req_ready;
    pop       = rsp_valid && rsp_ready && !flush;
  end

  // Word read at acceptance; out-of-range fetches never touch the store.
  always_comb begin
    fetch_word = '0;
    if (req_in_range) begin
      fetch_word = mem[req_addr[IDX_W-1:0]];
    end
  end

  // Head of the queue drives the response, forced to zero when empty.
  always_comb begin
    rsp_data = '0;
    rsp_addr = '0;
    rsp_err  = 1'b0;
    if (rsp_valid) begin
      rsp_data = q_data[rd_ptr];
      rsp_addr = q_addr[rd_ptr];
      rsp_err  = q_err[rd_ptr];
    end
  end

  // Program-load writes; the store survives reset but no write happens during it.
  always_ff @(posedge clk) begin
    if (rst_n && ld_en && ld_in_range) begin
      mem[ld_addr[IDX_W-1:0]] <= ld_data;
    end
  end

  // Queue payload storage; occupancy is tracked separately, so no reset needed.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      q_data[wr_ptr] <= fetch_word;
      q_addr[wr_ptr] <= req_addr;
      q_err[wr_ptr]  <= !req_in_range;
    end
  end

  // Queue pointers, occupancy and the accepted-fetch counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= 2'd0;
      fetch_cnt <= 16'h0000;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr    <= ~wr_ptr;
        fetch_cnt <= fetch_cnt + 16'd1;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
